// File: rtl/uart_rx_ext.sv
// UART receiver with 2-of-3 mid-bit voting, optional parity, 1-2 stop bits,
// break detection, and a held output frame with a valid/ready handshake and an overrun pulse.
module uart_rx_ext #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 115_200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_serial_i,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 break_det_o,
  output logic                 overrun_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int H            = CLKS_PER_BIT / 2;
  localparam int TW           = $clog2(CLKS_PER_BIT);
  localparam int BW           = $clog2(DATA_BITS);

  localparam logic [TW-1:0] T_S0  = TW'(H - 1);
  localparam logic [TW-1:0] T_S1  = TW'(H);
  localparam logic [TW-1:0] T_DEC = TW'(H + 1);
  localparam logic [TW-1:0] T_END = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_ONE = TW'(1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] B_ONE  = BW'(1);

  if (CLKS_PER_BIT < 8) begin : g_bad_baud
    $error("uart_rx_ext: CLKS_PER_BIT must be at least 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_ext: DATA_BITS must be in 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_rx_ext: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_rx_ext: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE, S_WAIT_IDLE
  } state_e;

  state_e                 state_q;
  logic                   sync1_q, rxs_q;
  logic [TW-1:0]          t_q;
  logic [BW-1:0]          bitCnt_q;
  logic                   stopCnt_q;
  logic [1:0]             samp_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   parAcc_q, parErr_q, frameErr_q, allZero_q, brk_q;
  logic                   rx_valid_q, parity_err_q, frame_err_q, break_det_q, overrun_q;
  logic [DATA_BITS-1:0]   rx_data_q;
  logic                   majBit;

  // Third vote is the live synchronized sample, so the bit is decided at t=H+1.
  assign majBit = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs_q) | (samp_q[1] & rxs_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rx_serial_i;
      rxs_q   <= sync1_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      t_q          <= '0;
      bitCnt_q     <= '0;
      stopCnt_q    <= 1'b0;
      samp_q       <= 2'b11;
      shift_q      <= '0;
      parAcc_q     <= 1'b0;
      parErr_q     <= 1'b0;
      frameErr_q   <= 1'b0;
      allZero_q    <= 1'b1;
      brk_q        <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_data_q    <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      break_det_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (rx_valid_q && rx_ready_i) rx_valid_q <= 1'b0;

      if (state_q inside {S_START, S_DATA, S_PARITY, S_STOP}) begin
        t_q <= (t_q == T_END) ? '0 : t_q + T_ONE;
        if (t_q == T_S0) samp_q[0] <= rxs_q;
        if (t_q == T_S1) samp_q[1] <= rxs_q;
      end

      case (state_q)
        S_IDLE: begin
          if (!rxs_q) begin
            state_q    <= S_START;
            t_q        <= '0;
            bitCnt_q   <= '0;
            stopCnt_q  <= 1'b0;
            shift_q    <= '0;
            parAcc_q   <= 1'b0;
            parErr_q   <= 1'b0;
            frameErr_q <= 1'b0;
            allZero_q  <= 1'b1;
            brk_q      <= 1'b0;
          end
        end
        S_START: begin
          if (t_q == T_DEC && majBit) begin
            state_q <= S_IDLE;
            t_q     <= '0;
          end else if (t_q == T_END) begin
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (t_q == T_DEC) begin
            shift_q   <= {majBit, shift_q[DATA_BITS-1:1]};
            parAcc_q  <= parAcc_q ^ majBit;
            allZero_q <= allZero_q & ~majBit;
          end
          if (t_q == T_END) begin
            if (bitCnt_q == B_LAST) state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
            else                    bitCnt_q <= bitCnt_q + B_ONE;
          end
        end
        S_PARITY: begin
          if (t_q == T_DEC) begin
            if (PARITY == 1) parErr_q <= ~(parAcc_q ^ majBit);
            else             parErr_q <= parAcc_q ^ majBit;
            allZero_q <= allZero_q & ~majBit;
          end
          if (t_q == T_END) state_q <= S_STOP;
        end
        S_STOP: begin
          // The last stop bit is not waited out, so a back-to-back start edge is not missed.
          if (t_q == T_DEC) begin
            if (!majBit) frameErr_q <= 1'b1;
            if (!stopCnt_q) brk_q <= allZero_q & ~majBit;
            if (stopCnt_q == 1'(STOP_BITS - 1)) begin
              state_q <= S_DONE;
              t_q     <= '0;
            end
          end else if (t_q == T_END) begin
            stopCnt_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (!rx_valid_q || rx_ready_i) begin
            rx_valid_q   <= 1'b1;
            rx_data_q    <= shift_q;
            parity_err_q <= parErr_q;
            frame_err_q  <= frameErr_q;
            break_det_q  <= brk_q;
          end else begin
            overrun_q <= 1'b1;
          end
          state_q <= frameErr_q ? S_WAIT_IDLE : S_IDLE;
        end
        S_WAIT_IDLE: begin
          if (rxs_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rx_valid_o   = rx_valid_q;
  assign rx_data_o    = rx_data_q;
  assign parity_err_o = parity_err_q;
  assign frame_err_o  = frame_err_q;
  assign break_det_o  = break_det_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_uart_rx_ext.sv
// Bench for uart_rx_ext: an 8N1 and an 8E1 instance driven with directed and random frames,
// expected frames computed from the frame contents by a small behavioural model.
module tb_uart_rx_ext;

  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD_R = 100_000;
  localparam int CPB    = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic lineN = 1'b1, lineE = 1'b1;
  logic readyN = 1'b1, readyE = 1'b1;

  logic       vN, peN, feN, bdN, ovN;
  logic [7:0] dN;
  logic       vE, peE, feE, bdE, ovE;
  logic [7:0] dE;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       pe;
    logic       fe;
    logic       bd;
  } rec_t;

  rec_t qN[$];
  rec_t qE[$];
  rec_t monN, monE;
  int   rdN = 0, rdE = 0;
  int   validCycN = 0, overrunN = 0;

  uart_rx_ext #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD_R), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dutN (
    .clk_i(clk), .rst_ni(rst_n), .rx_serial_i(lineN), .rx_valid_o(vN), .rx_ready_i(readyN),
    .rx_data_o(dN), .parity_err_o(peN), .frame_err_o(feN), .break_det_o(bdN), .overrun_o(ovN));

  uart_rx_ext #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD_R), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dutE (
    .clk_i(clk), .rst_ni(rst_n), .rx_serial_i(lineE), .rx_valid_o(vE), .rx_ready_i(readyE),
    .rx_data_o(dE), .parity_err_o(peE), .frame_err_o(feE), .break_det_o(bdE), .overrun_o(ovE));

  always #5 clk = ~clk;

  // Accepted transfers are logged at the falling edge, away from the DUT's sampling edge.
  always @(negedge clk) begin
    if (vN && readyN) begin
      monN.data = dN; monN.pe = peN; monN.fe = feN; monN.bd = bdN;
      qN.push_back(monN);
    end
    if (vE && readyE) begin
      monE.data = dE; monE.pe = peE; monE.fe = feE; monE.bd = bdE;
      qE.push_back(monE);
    end
    if (vN) validCycN++;
    if (ovN) overrunN++;
  end

  function automatic rec_t modelN(input logic [7:0] data, input logic stopBit);
    rec_t r;
    r.data = data;
    r.pe   = 1'b0;
    r.fe   = (stopBit == 1'b0);
    r.bd   = (data == 8'h00) && (stopBit == 1'b0);
    return r;
  endfunction

  function automatic rec_t modelE(input logic [7:0] data, input logic parBit, input logic stopBit);
    rec_t r;
    int ones;
    ones = $countones(data) + int'(parBit);
    r.data = data;
    r.pe   = (ones % 2) != 0;
    r.fe   = (stopBit == 1'b0);
    r.bd   = (data == 8'h00) && (parBit == 1'b0) && (stopBit == 1'b0);
    return r;
  endfunction

  task automatic idleClks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic setLine(input int which, input logic val);
    if (which == 0) lineN = val;
    else            lineE = val;
  endtask

  // Drives frame bit positions firstBit..lastBit (0 = start, 1..8 data, then parity on E, then stop).
  task automatic applyStimulus(input int which, input logic [7:0] data, input logic parBit,
                               input logic stopBit, input int firstBit, input int lastBit);
    logic bits [11];
    int n;
    n = 0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < 8; i++) begin bits[n] = data[i]; n++; end
    if (which == 1) begin bits[n] = parBit; n++; end
    bits[n] = stopBit; n++;
    for (int k = firstBit; k <= lastBit && k < n; k++) begin
      setLine(which, bits[k]);
      idleClks(CPB);
    end
  endtask

  task automatic sendFrame(input int which, input logic [7:0] data, input logic parBit, input logic stopBit);
    applyStimulus(which, data, parBit, stopBit, 0, 10);
    setLine(which, 1'b1);
    idleClks(2 * CPB);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idleClks(3);
    checks++; if (vN !== 1'b0)  begin failures++; $display("[TB] FAIL reset_valid_N got=%b exp=0", vN); end
    checks++; if (dN !== 8'h00) begin failures++; $display("[TB] FAIL reset_data_N got=%h exp=00", dN); end
    checks++; if ({peN, feN, bdN, ovN} !== 4'b0) begin failures++; $display("[TB] FAIL reset_flags_N got=%b exp=0000", {peN, feN, bdN, ovN}); end
    checks++; if (vE !== 1'b0)  begin failures++; $display("[TB] FAIL reset_valid_E got=%b exp=0", vE); end
    checks++; if (dE !== 8'h00) begin failures++; $display("[TB] FAIL reset_data_E got=%h exp=00", dE); end
    checks++; if ({peE, feE, bdE, ovE} !== 4'b0) begin failures++; $display("[TB] FAIL reset_flags_E got=%b exp=0000", {peE, feE, bdE, ovE}); end
    rst_n = 1'b1;
    idleClks(2 * CPB);
  endtask

  task automatic test_8n1();
    rec_t exp;
    int baseV;
    logic [7:0] data;
    logic stopBit;
    baseV = validCycN;
    sendFrame(0, 8'hA5, 1'b0, 1'b1);
    exp = modelN(8'hA5, 1'b1);
    checks++;
    if (qN.size() - rdN != 1) begin
      failures++; $display("[TB] FAIL a5_frames got=%0d exp=1", qN.size() - rdN); rdN = qN.size();
    end else begin
      checks++;
      if (qN[rdN] !== exp) begin failures++; $display("[TB] FAIL a5_frame got=%h exp=%h", qN[rdN], exp); end
      rdN++;
    end
    checks++;
    if (validCycN - baseV != 1) begin failures++; $display("[TB] FAIL a5_valid_cycles got=%0d exp=1", validCycN - baseV); end

    for (int i = 0; i < 6; i++) begin
      data    = 8'($urandom);
      stopBit = ($urandom_range(0, 3) != 0);
      if (i == 2) begin data = 8'h00; stopBit = 1'b0; end
      sendFrame(0, data, 1'b0, stopBit);
      exp = modelN(data, stopBit);
      checks++;
      if (qN.size() - rdN != 1) begin
        failures++; $display("[TB] FAIL rand_n_frames[%0d] got=%0d exp=1", i, qN.size() - rdN); rdN = qN.size();
      end else begin
        checks++;
        if (qN[rdN] !== exp) begin failures++; $display("[TB] FAIL rand_n_frame[%0d] got=%h exp=%h", i, qN[rdN], exp); end
        rdN++;
      end
    end
  endtask

  task automatic test_parity_8e1();
    rec_t exp;
    logic [7:0] data;
    logic parBit;
    sendFrame(1, 8'h37, 1'b0, 1'b1);
    exp = modelE(8'h37, 1'b0, 1'b1);
    checks++;
    if (qE.size() - rdE != 1) begin
      failures++; $display("[TB] FAIL p37_frames got=%0d exp=1", qE.size() - rdE); rdE = qE.size();
    end else begin
      checks++;
      if (qE[rdE] !== exp) begin failures++; $display("[TB] FAIL p37_frame got=%h exp=%h", qE[rdE], exp); end
      rdE++;
    end
    for (int i = 0; i < 5; i++) begin
      data   = 8'($urandom);
      parBit = 1'($urandom);
      sendFrame(1, data, parBit, 1'b1);
      exp = modelE(data, parBit, 1'b1);
      checks++;
      if (qE.size() - rdE != 1) begin
        failures++; $display("[TB] FAIL rand_e_frames[%0d] got=%0d exp=1", i, qE.size() - rdE); rdE = qE.size();
      end else begin
        checks++;
        if (qE[rdE] !== exp) begin failures++; $display("[TB] FAIL rand_e_frame[%0d] got=%h exp=%h", i, qE[rdE], exp); end
        rdE++;
      end
    end
  endtask

  task automatic test_frame_err();
    rec_t exp;
    sendFrame(0, 8'h3C, 1'b0, 1'b0);
    exp = modelN(8'h3C, 1'b0);
    checks++;
    if (qN.size() - rdN != 1) begin
      failures++; $display("[TB] FAIL ferr_frames got=%0d exp=1", qN.size() - rdN); rdN = qN.size();
    end else begin
      checks++;
      if (qN[rdN] !== exp) begin failures++; $display("[TB] FAIL ferr_frame got=%h exp=%h", qN[rdN], exp); end
      rdN++;
    end
    sendFrame(0, 8'h55, 1'b0, 1'b1);
    exp = modelN(8'h55, 1'b1);
    checks++;
    if (qN.size() - rdN != 1) begin
      failures++; $display("[TB] FAIL after_ferr_frames got=%0d exp=1", qN.size() - rdN); rdN = qN.size();
    end else begin
      checks++;
      if (qN[rdN] !== exp) begin failures++; $display("[TB] FAIL after_ferr_frame got=%h exp=%h", qN[rdN], exp); end
      rdN++;
    end
  endtask

  task automatic test_break();
    rec_t exp;
    lineN = 1'b0;
    idleClks(20 * CPB);
    lineN = 1'b1;
    idleClks(2 * CPB);
    exp = modelN(8'h00, 1'b0);
    checks++;
    if (qN.size() - rdN != 1) begin
      failures++; $display("[TB] FAIL break_frames got=%0d exp=1", qN.size() - rdN); rdN = qN.size();
    end else begin
      checks++;
      if (qN[rdN] !== exp) begin failures++; $display("[TB] FAIL break_frame got=%h exp=%h", qN[rdN], exp); end
      rdN++;
    end
    sendFrame(0, 8'h0F, 1'b0, 1'b1);
    exp = modelN(8'h0F, 1'b1);
    checks++;
    if (qN.size() - rdN != 1) begin
      failures++; $display("[TB] FAIL after_break_frames got=%0d exp=1", qN.size() - rdN); rdN = qN.size();
    end else begin
      checks++;
      if (qN[rdN] !== exp) begin failures++; $display("[TB] FAIL after_break_frame got=%h exp=%h", qN[rdN], exp); end
      rdN++;
    end
  endtask

  task automatic test_back_to_back();
    int baseO;
    rec_t exp;
    readyN = 1'b0;
    baseO = overrunN;
    sendFrame(0, 8'h11, 1'b0, 1'b1);
    checks++; if (overrunN - baseO != 0) begin failures++; $display("[TB] FAIL ovr_first got=%0d exp=0", overrunN - baseO); end
    sendFrame(0, 8'h22, 1'b0, 1'b1);
    checks++; if (overrunN - baseO != 1) begin failures++; $display("[TB] FAIL ovr_second got=%0d exp=1", overrunN - baseO); end
    checks++; if (vN !== 1'b1)  begin failures++; $display("[TB] FAIL ovr_valid got=%b exp=1", vN); end
    checks++; if (dN !== 8'h11) begin failures++; $display("[TB] FAIL ovr_data got=%h exp=11", dN); end
    readyN = 1'b1;
    @(negedge clk);
    checks++; if (vN !== 1'b1) begin failures++; $display("[TB] FAIL accept_valid_before got=%b exp=1", vN); end
    @(negedge clk);
    checks++; if (vN !== 1'b0) begin failures++; $display("[TB] FAIL accept_valid_after got=%b exp=0", vN); end
    idleClks(1);
    exp = modelN(8'h11, 1'b1);
    checks++;
    if (qN.size() - rdN != 1) begin
      failures++; $display("[TB] FAIL accept_frames got=%0d exp=1", qN.size() - rdN); rdN = qN.size();
    end else begin
      checks++;
      if (qN[rdN] !== exp) begin failures++; $display("[TB] FAIL accept_frame got=%h exp=%h", qN[rdN], exp); end
      rdN++;
    end
  endtask

  task automatic test_glitch_reset();
    rec_t exp;
    int baseO;
    readyN = 1'b0;
    sendFrame(0, 8'h33, 1'b0, 1'b1);
    baseO = overrunN;
    lineN = 1'b0;
    idleClks(3);
    lineN = 1'b1;
    idleClks(3 * CPB);
    checks++; if (vN !== 1'b1 || dN !== 8'h33) begin failures++; $display("[TB] FAIL glitch_hold got=%b/%h exp=1/33", vN, dN); end
    checks++; if (overrunN != baseO) begin failures++; $display("[TB] FAIL glitch_overrun got=%0d exp=0", overrunN - baseO); end

    applyStimulus(0, 8'h5A, 1'b0, 1'b1, 0, 3);
    rst_n = 1'b0;
    #1;
    checks++; if (vN !== 1'b0)  begin failures++; $display("[TB] FAIL midreset_valid got=%b exp=0", vN); end
    checks++; if (dN !== 8'h00) begin failures++; $display("[TB] FAIL midreset_data got=%h exp=00", dN); end
    checks++; if ({peN, feN, bdN, ovN} !== 4'b0) begin failures++; $display("[TB] FAIL midreset_flags got=%b exp=0000", {peN, feN, bdN, ovN}); end
    applyStimulus(0, 8'h5A, 1'b0, 1'b1, 4, 10);
    lineN = 1'b1;
    readyN = 1'b1;
    idleClks(CPB);
    rst_n = 1'b1;
    idleClks(2 * CPB);
    checks++; if (qN.size() != rdN) begin failures++; $display("[TB] FAIL midreset_frames got=%0d exp=0", qN.size() - rdN); rdN = qN.size(); end
    sendFrame(0, 8'h5A, 1'b0, 1'b1);
    exp = modelN(8'h5A, 1'b1);
    checks++;
    if (qN.size() - rdN != 1) begin
      failures++; $display("[TB] FAIL post_reset_frames got=%0d exp=1", qN.size() - rdN); rdN = qN.size();
    end else begin
      checks++;
      if (qN[rdN] !== exp) begin failures++; $display("[TB] FAIL post_reset_frame got=%h exp=%h", qN[rdN], exp); end
      rdN++;
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity_8e1();
    test_frame_err();
    test_break();
    test_back_to_back();
    test_glitch_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_ext.md
UART_RX_EXT -- requirements
Module: uart_rx_ext

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115_200, serial bit rate; CLKS_PER_BIT = CLK_FREQ_HZ/BAUD (integer divide), H = CLKS_PER_BIT/2; CLKS_PER_BIT < 8 SHALL be a elaboration-time error.
REQ-003 Parameter DATA_BITS, default 8, data bits per frame, legal 5..9; other values SHALL be an elaboration-time error.
REQ-004 Parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 Parameter STOP_BITS, default 1, stop bits checked per frame, legal 1 or 2.
REQ-006 clk  input  1  single system clock; all logic rising-edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 rx_serial  input  1  asynchronous serial line, idle high.
REQ-009 rx_valid  output  1  held-frame-available flag, level until accepted.
REQ-010 rx_ready  input  1  consumer accept; transfer when rx_valid && rx_ready.
REQ-011 rx_data  output  DATA_BITS  received data, LSB first on line, bit 0 = first data bit.
REQ-012 parity_err  output  1  held frame parity mismatch; 0 when PARITY=0.
REQ-013 frame_err  output  1  held frame had a stop bit sampled low.
REQ-014 break_det  output  1  held frame was a line break.
REQ-015 overrun  output  1  one-clk pulse when a completed frame is dropped.

Function
REQ-016 rx_serial SHALL pass a 2-flop synchronizer (both flops reset to 1); all sampling uses the second flop (rxs).
REQ-017 States SHALL be IDLE, START, DATA, PARITY, STOP, DONE, WAIT_IDLE.
REQ-018 IDLE: rxs==0 -> START; bit timer t cleared so first START cycle has t=0.
REQ-019 Each bit period spans t=0..CLKS_PER_BIT-1; t wraps to 0 at period end and the next bit period begins immediately.
REQ-020 Every bit value SHALL be the 2-of-3 majority of rxs at t=H-1, H, H+1, decided at t=H+1.
REQ-021 START: majority 1 -> IDLE (false start, no outputs change); majority 0 -> continue to DATA at period end.
REQ-022 DATA: DATA_BITS periods, shift decided bits in LSB first; then PARITY if PARITY!=0, else STOP.
REQ-023 PARITY: error when XOR(data bits, parity bit) != 1 (odd) or != 0 (even).
REQ-024 STOP: STOP_BITS periods; frame_err if any stop decision is 0; after the last stop decision (t=H+1, remainder of period not waited) -> DONE.
REQ-025 Break: all data bits 0, parity bit (if present) 0 and first stop bit 0 -> break_det=1 and frame_err=1 for that frame.
REQ-026 DONE (one cycle): if rx_valid==0 or rx_ready==1 in that cycle, load rx_data/parity_err/frame_err/break_det from the frame and set rx_valid=1 next cycle; else drop the frame, keep held outputs, pulse overrun for one clk.
REQ-027 DONE -> WAIT_IDLE if frame_err, else -> IDLE; WAIT_IDLE -> IDLE on first cycle rxs==1 (no frames while line held low).
REQ-028 rx_valid SHALL clear the cycle after rx_valid && rx_ready unless DONE reloads in that same cycle (simultaneous accept and reload keeps rx_valid=1 with new data, no overrun).
REQ-029 Held rx_data and error flags SHALL remain stable while rx_valid=1 and not accepted.
REQ-030 Latency: rx_valid rises 1 clk after DONE; DONE follows the last stop decision by 1 clk.

Reset
REQ-031 rst_n low SHALL immediately force state IDLE, t=0, shift register 0, synchronizer flops 1, rx_valid=0, rx_data=0, parity_err=0, frame_err=0, break_det=0, overrun=0.
REQ-032 Reset mid-frame SHALL discard the partial frame; after release a frame is recognized only from a new falling edge seen in IDLE.

Verification (CLK_FREQ_HZ=1_600_000, BAUD=100_000, CLKS_PER_BIT=16)
REQ-033 8N1, rx_ready=1, send 0xA5 -> rx_valid high exactly 1 clk, rx_data=0xA5, all error flags 0.
REQ-034 8E1, send 0x37 with parity bit 0 -> rx_data=0x37, parity_err=1, frame_err=0.
REQ-035 8N1, 0x3C with stop bit low, line then high, then 0x55 -> first frame frame_err=1 break_det=0; second 0x55 clean.
REQ-036 8N1, line low for 20 bit times, then high, then 0x0F -> exactly one frame rx_data=0x00 frame_err=1 break_det=1, then 0x0F clean.
REQ-037 rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, one overrun pulse at second DONE; then rx_ready=1 -> rx_valid drops next clk.
REQ-038 3-clk low glitch on idle line -> no rx_valid; reset asserted mid-DATA of 0x5A -> all outputs 0, next clean 0x5A received correctly.
